box_pack_ctrl: RTL and testbench

BOX_PACK_CTRL -- requirements
Module: box_pack_ctrl

---
 rtl/box_pack_pkg.sv | 30 +++
 rtl/box_seal_timer.sv | 32 +++
 rtl/box_pack_ctrl.sv | 106 ++++++++++
 tb/tb_box_pack_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/box_pack_pkg.sv
`default_nettype none
// ============================================================================
// box_pack_pkg : color encodings, FSM state type and color-to-mask helper
// Rev 1.0 : initial release
// ============================================================================
package box_pack_pkg;

  localparam logic [1:0] COLOR_RED     = 2'b00;
  localparam logic [1:0] COLOR_BLUE    = 2'b01;
  localparam logic [1:0] COLOR_GREEN   = 2'b10;
  localparam logic [1:0] COLOR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-hot have-mask bit for a color; the invalid code maps to no bit.
  function automatic logic [2:0] color_bit(input logic [1:0] color);
    case (color)
      COLOR_RED:   color_bit = 3'b001;
      COLOR_BLUE:  color_bit = 3'b010;
      COLOR_GREEN: color_bit = 3'b100;
      default:     color_bit = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_seal_timer.sv
`default_nettype none
// ============================================================================
// box_seal_timer : loadable down-counter timing how long the seal is held
// Rev 1.0 : initial release
// ============================================================================
module box_seal_timer #(
  parameter int SEAL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= 4'(SEAL_CYCLES);
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Count of 1 marks the final seal cycle.
  assign o_expire = (r_cnt == 4'd1);

endmodule
`default_nettype wire

// File: rtl/box_pack_ctrl.sv
`default_nettype none
// ============================================================================
// box_pack_ctrl : fills a box with one ball of each color, then seals it
// Rev 1.0 : initial release
// ============================================================================
module box_pack_ctrl
  import box_pack_pkg::*;
#(
  parameter int SEAL_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ball_valid,
  input  logic [1:0]       ball_color,
  output logic             ball_ready,
  output logic             accept,
  output logic             divert,
  output logic             err,
  output logic             seal,
  output logic             box_done,
  output logic [CNT_W-1:0] box_count
);

  state_t           r_state;
  logic [2:0]       r_have;
  logic             r_accept;
  logic             r_divert;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic       w_xfer;
  logic [2:0] w_bit;
  logic [2:0] w_new_have;
  logic       w_invalid;
  logic       w_dup;
  logic       w_complete;
  logic       w_expire;

  assign ball_ready = (r_state == ST_FILL) && !rst;
  assign w_xfer     = ball_valid && ball_ready;
  assign w_bit      = color_bit(ball_color);
  assign w_invalid  = (ball_color == COLOR_INVALID);
  assign w_dup      = |(r_have & w_bit);
  assign w_new_have = r_have | w_bit;
  // Timer loads on the very edge the last missing color arrives.
  assign w_complete = w_xfer && !w_invalid && !w_dup && (w_new_have == 3'b111);

  box_seal_timer #(
    .SEAL_CYCLES(SEAL_CYCLES)
  ) u_seal_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_complete),
    .i_dec   (r_state == ST_SEAL),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_have   <= 3'b000;
      r_accept <= 1'b0;
      r_divert <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_accept <= 1'b0;
      r_divert <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_xfer) begin
            if (w_invalid) begin
              r_err <= 1'b1;
            end else if (w_dup) begin
              r_divert <= 1'b1;
            end else begin
              r_accept <= 1'b1;
              r_have   <= w_new_have;
              if (w_complete) r_state <= ST_SEAL;
            end
          end
        end
        ST_SEAL: begin
          if (w_expire) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_FILL;
          r_have  <= 3'b000;
          if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign accept    = r_accept;
  assign divert    = r_divert;
  assign err       = r_err;
  assign seal      = (r_state == ST_SEAL);
  assign box_done  = (r_state == ST_DONE);
  assign box_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_box_pack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_box_pack_ctrl : directed self-checking bench for box_pack_ctrl
// Rev 1.0 : initial release
// ============================================================================
module tb_box_pack_ctrl;

  localparam int CNT_W = 2;
  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ball_valid = 1'b0;
  logic [1:0]       ball_color = 2'b00;
  logic             ball_ready;
  logic             accept;
  logic             divert;
  logic             err;
  logic             seal;
  logic             box_done;
  logic [CNT_W-1:0] box_count;

  int total = 0;
  int bad   = 0;
  int done_seen;

  box_pack_ctrl #(
    .SEAL_CYCLES(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ball_valid(ball_valid),
    .ball_color(ball_color),
    .ball_ready(ball_ready),
    .accept    (accept),
    .divert    (divert),
    .err       (err),
    .seal      (seal),
    .box_done  (box_done),
    .box_count (box_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ball_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", 8'(ball_ready), 8'd0);
    rst = 1'b0;
    #1;
  endtask

  // Present one ball for one edge, then check the resulting pulse trio.
  task automatic send(input string tag, input logic [1:0] c,
                      input logic ea, input logic ed, input logic ee);
    ball_valid = 1'b1;
    ball_color = c;
    tick();
    ball_valid = 1'b0;
    ball_color = X;
    chk({tag, "_pulses"}, {5'd0, accept, divert, err}, {5'd0, ea, ed, ee});
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_ready", 8'(ball_ready), 8'd1);
    chk("reset_count", 8'(box_count), 8'd0);
    chk("reset_seal_done", {6'd0, seal, box_done}, 8'd0);
    chk("reset_pulses", {5'd0, accept, divert, err}, 8'd0);

    // R, G, B on consecutive cycles
    send("rgb_r", R, 1'b1, 1'b0, 1'b0);
    send("rgb_g", G, 1'b1, 1'b0, 1'b0);
    send("rgb_b", B, 1'b1, 1'b0, 1'b0);
    chk("rgb_seal1", 8'(seal), 8'd1);
    chk("rgb_ready_seal", 8'(ball_ready), 8'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("rgb_seal_n", {6'd0, seal, box_done}, 8'b10);
    end
    tick();
    chk("rgb_done", {6'd0, seal, box_done}, 8'b01);
    chk("rgb_count_in_done", 8'(box_count), 8'd0);
    tick();
    chk("rgb_after_done", {6'd0, seal, box_done}, 8'b00);
    chk("rgb_count", 8'(box_count), 8'd1);
    chk("rgb_ready_back", 8'(ball_ready), 8'd1);

    // R, R, B, G with a duplicate
    do_reset();
    send("dup_r1", R, 1'b1, 1'b0, 1'b0);
    send("dup_r2", R, 1'b0, 1'b1, 1'b0);
    send("dup_b", B, 1'b1, 1'b0, 1'b0);
    send("dup_g", G, 1'b1, 1'b0, 1'b0);
    tick();
    chk("dup_pulse_clear", {5'd0, accept, divert, err}, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("dup_count", 8'(box_count), 8'd1);

    // Invalid color between R and B
    do_reset();
    send("inv_r", R, 1'b1, 1'b0, 1'b0);
    send("inv_x", X, 1'b0, 1'b0, 1'b1);
    send("inv_b", B, 1'b1, 1'b0, 1'b0);
    chk("inv_still_fill", 8'(seal), 8'd0);
    send("inv_g", G, 1'b1, 1'b0, 1'b0);
    chk("inv_sealed", 8'(seal), 8'd1);

    // Red held through SEAL and DONE
    ball_valid = 1'b1;
    ball_color = R;
    #1;
    chk("hold_ready_0", 8'(ball_ready), 8'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("hold_ready_n", 8'(ball_ready), 8'd0);
      chk("hold_no_pulse", {5'd0, accept, divert, err}, 8'd0);
    end
    tick();
    chk("hold_ready_fill", 8'(ball_ready), 8'd1);
    chk("hold_count", 8'(box_count), 8'd1);
    chk("hold_no_early_accept", 8'(accept), 8'd0);
    tick();
    ball_valid = 1'b0;
    chk("hold_accept", {5'd0, accept, divert, err}, 8'b100);
    send("hold_r_again", R, 1'b0, 1'b1, 1'b0);
    send("hold_b", B, 1'b1, 1'b0, 1'b0);

    // Reset on the 2nd SEAL cycle
    do_reset();
    send("abort_r", R, 1'b1, 1'b0, 1'b0);
    send("abort_g", G, 1'b1, 1'b0, 1'b0);
    send("abort_b", B, 1'b1, 1'b0, 1'b0);
    tick();
    chk("abort_seal2", 8'(seal), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_seal_off", {6'd0, seal, box_done}, 8'd0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (box_done) done_seen++;
    end
    chk("abort_no_done", 8'(done_seen), 8'd0);
    chk("abort_count", 8'(box_count), 8'd0);
    send("abort_mask_r", R, 1'b1, 1'b0, 1'b0);
    send("abort_mask_g", G, 1'b1, 1'b0, 1'b0);
    send("abort_mask_b", B, 1'b1, 1'b0, 1'b0);

    // Five boxes with a 2-bit counter
    do_reset();
    done_seen = 0;
    for (int bx = 0; bx < 5; bx++) begin
      send("sat_r", R, 1'b1, 1'b0, 1'b0);
      send("sat_g", G, 1'b1, 1'b0, 1'b0);
      send("sat_b", B, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
        tick();
        if (box_done) done_seen++;
      end
      chk("sat_count_step", 8'(box_count), (bx >= 2) ? 8'd3 : 8'(bx + 1));
    end
    chk("sat_done_pulses", 8'(done_seen), 8'd5);
    chk("sat_count_final", 8'(box_count), 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
